// File: rtl/cm3_ahb_bus_arbiter.sv
// Three-port AHB-Lite master arbiter: merges D-code, System and I-code onto one master bus,
// holding the address phase of any port that loses arbitration until it is served.
module cm3_ahb_bus_arbiter #(
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned BURST_LOCK = 1,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    // Port 0 (D-code)
    input  logic          HSELS0,
    input  logic [AW-1:0] HADDRS0,
    input  logic [1:0]    HTRANSS0,
    input  logic [2:0]    HSIZES0,
    input  logic [2:0]    HBURSTS0,
    input  logic [3:0]    HPROTS0,
    input  logic          HWRITES0,
    input  logic [DW-1:0] HWDATAS0,
    input  logic          HREADYS0,
    output logic          HREADYOUTS0,
    output logic [1:0]    HRESPS0,
    output logic [DW-1:0] HRDATAS0,
    // Port 1 (System)
    input  logic          HSELS1,
    input  logic [AW-1:0] HADDRS1,
    input  logic [1:0]    HTRANSS1,
    input  logic [2:0]    HSIZES1,
    input  logic [2:0]    HBURSTS1,
    input  logic [3:0]    HPROTS1,
    input  logic          HWRITES1,
    input  logic [DW-1:0] HWDATAS1,
    input  logic          HREADYS1,
    output logic          HREADYOUTS1,
    output logic [1:0]    HRESPS1,
    output logic [DW-1:0] HRDATAS1,
    // Port 2 (I-code)
    input  logic          HSELS2,
    input  logic [AW-1:0] HADDRS2,
    input  logic [1:0]    HTRANSS2,
    input  logic [2:0]    HSIZES2,
    input  logic [2:0]    HBURSTS2,
    input  logic [3:0]    HPROTS2,
    input  logic          HWRITES2,
    input  logic [DW-1:0] HWDATAS2,
    input  logic          HREADYS2,
    output logic          HREADYOUTS2,
    output logic [1:0]    HRESPS2,
    output logic [DW-1:0] HRDATAS2,
    // Master bus
    output logic [AW-1:0] HADDRM,
    output logic [1:0]    HTRANSM,
    output logic [2:0]    HSIZEM,
    output logic [2:0]    HBURSTM,
    output logic [3:0]    HPROTM,
    output logic          HWRITEM,
    output logic [DW-1:0] HWDATAM,
    output logic          HREADYM,
    output logic [1:0]    HMASTERM,
    input  logic          HREADYOUTM,
    input  logic [1:0]    HRESPM,
    input  logic [DW-1:0] HRDATAM
);

    localparam logic [1:0] TransIdle = 2'b00;
    localparam logic [1:0] TransBusy = 2'b01;
    localparam logic [1:0] TransSeq  = 2'b11;

    typedef enum logic [1:0] {StIdle, StWait, StData} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
        logic          write;
    } addr_ph_t;

    addr_ph_t      live [3];
    logic [DW-1:0] wdata [3];
    logic [2:0]    sel, rdy_in, rdy_out;

    state_t   state_q [3], state_d [3];
    addr_ph_t hold_q [3], hold_d [3];
    logic [1:0] addr_owner_q, data_owner_q, rr_last_q;

    logic [2:0] accept, req, grant_hit;
    logic [1:0] grant_idx, start_idx, own_trans;
    logic [2:0] cand;
    logic       found, lock, mst_valid;
    addr_ph_t   mst;

    assign live[0] = {HADDRS0, HTRANSS0, HSIZES0, HBURSTS0, HPROTS0, HWRITES0};
    assign live[1] = {HADDRS1, HTRANSS1, HSIZES1, HBURSTS1, HPROTS1, HWRITES1};
    assign live[2] = {HADDRS2, HTRANSS2, HSIZES2, HBURSTS2, HPROTS2, HWRITES2};
    assign wdata[0] = HWDATAS0;
    assign wdata[1] = HWDATAS1;
    assign wdata[2] = HWDATAS2;
    assign sel      = {HSELS2, HSELS1, HSELS0};
    assign rdy_in   = {HREADYS2, HREADYS1, HREADYS0};

    // Requests are masked while in reset so nothing reaches the bus during assertion.
    always_comb begin
        accept = '0;
        req    = '0;
        for (int i = 0; i < 3; i++) begin
            accept[i] = HRESETn & sel[i] & live[i].trans[1] & rdy_in[i];
            req[i]    = accept[i] | (state_q[i] == StWait);
        end
    end

    assign own_trans = live[addr_owner_q].trans;
    assign lock = (BURST_LOCK != 0) && HRESETn && sel[addr_owner_q] &&
                  ((own_trans == TransSeq) || (own_trans == TransBusy));

    // Round-robin starts searching just after the last port that issued a transfer.
    always_comb begin
        start_idx = 2'd0;
        if (RR_MODE != 0) begin
            start_idx = (rr_last_q == 2'd2) ? 2'd0 : rr_last_q + 2'd1;
        end
        grant_idx = addr_owner_q;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, start_idx} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!found && req[cand[1:0]]) begin
                grant_idx = cand[1:0];
                found     = 1'b1;
            end
        end
        if (lock) grant_idx = addr_owner_q;
    end

    always_comb begin
        mst       = (state_q[grant_idx] == StWait) ? hold_q[grant_idx] : live[grant_idx];
        mst_valid = req[grant_idx] | lock;
    end

    assign HADDRM   = mst.addr;
    assign HTRANSM  = mst_valid ? mst.trans : TransIdle;
    assign HSIZEM   = mst.size;
    assign HBURSTM  = mst.burst;
    assign HPROTM   = mst.prot;
    assign HWRITEM  = mst.write;
    assign HMASTERM = grant_idx;
    assign HREADYM  = HREADYOUTM;
    assign HWDATAM  = wdata[data_owner_q];

    assign grant_hit = HREADYOUTM ? (3'b001 << grant_idx) : 3'b000;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            unique case (state_q[i])
                StIdle, StData: begin
                    if (accept[i]) begin
                        if (grant_hit[i]) begin
                            state_d[i] = StData;
                        end else begin
                            state_d[i] = StWait;
                            hold_d[i]  = live[i];
                        end
                    end else if ((state_q[i] == StData) && HREADYOUTM) begin
                        state_d[i] = StIdle;
                    end
                end
                StWait: if (grant_hit[i]) state_d[i] = StData;
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rdy_out[i] = (state_q[i] == StIdle) | ((state_q[i] == StData) & HREADYOUTM);
        end
    end

    assign HREADYOUTS0 = rdy_out[0];
    assign HREADYOUTS1 = rdy_out[1];
    assign HREADYOUTS2 = rdy_out[2];
    assign HRESPS0  = (state_q[0] == StData) ? HRESPM : 2'b00;
    assign HRESPS1  = (state_q[1] == StData) ? HRESPM : 2'b00;
    assign HRESPS2  = (state_q[2] == StData) ? HRESPM : 2'b00;
    assign HRDATAS0 = (state_q[0] == StData) ? HRDATAM : '0;
    assign HRDATAS1 = (state_q[1] == StData) ? HRDATAM : '0;
    assign HRDATAS2 = (state_q[2] == StData) ? HRDATAM : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StIdle;
                hold_q[i]  <= '0;
            end
            addr_owner_q <= 2'd0;
            data_owner_q <= 2'd0;
            rr_last_q    <= 2'd2;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
            if (HREADYOUTM) addr_owner_q <= grant_idx;
            if (HREADYOUTM && HTRANSM[1]) begin
                data_owner_q <= grant_idx;
                rr_last_q    <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_cm3_ahb_bus_arbiter.sv
// Bench for cm3_ahb_bus_arbiter: a fixed-priority and a round-robin instance share port stimulus;
// issued address phases are scoreboarded against an in-order expectation queue.
module tb_cm3_ahb_bus_arbiter;

    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;
    localparam logic [2:0] INCR4 = 3'b011;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [2:0]  sel;
    logic [31:0] addr [3];
    logic [1:0]  trans [3];
    logic [2:0]  size [3];
    logic [2:0]  burst [3];
    logic [3:0]  prot [3];
    logic [2:0]  wr;
    logic [31:0] wdata [3];
    logic        readyout_m;
    logic [1:0]  resp_m;
    logic [31:0] rdata_m;

    logic [2:0]  d_rdy, r_rdy;
    logic [1:0]  d_resp [3], r_resp [3];
    logic [31:0] d_rdata [3], r_rdata [3];
    logic [31:0] d_haddr, r_haddr, d_hwdata, r_hwdata;
    logic [1:0]  d_htrans, r_htrans, d_hmaster, r_hmaster;
    logic [2:0]  d_hsize, r_hsize, d_hburst, r_hburst;
    logic [3:0]  d_hprot, r_hprot;
    logic        d_hwrite, r_hwrite, d_hready, r_hready;

    always #5 HCLK = ~HCLK;

    cm3_ahb_bus_arbiter #(.RR_MODE(0), .BURST_LOCK(1), .AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS0(sel[0]), .HADDRS0(addr[0]), .HTRANSS0(trans[0]), .HSIZES0(size[0]),
        .HBURSTS0(burst[0]), .HPROTS0(prot[0]), .HWRITES0(wr[0]), .HWDATAS0(wdata[0]),
        .HREADYS0(d_rdy[0]), .HREADYOUTS0(d_rdy[0]), .HRESPS0(d_resp[0]), .HRDATAS0(d_rdata[0]),
        .HSELS1(sel[1]), .HADDRS1(addr[1]), .HTRANSS1(trans[1]), .HSIZES1(size[1]),
        .HBURSTS1(burst[1]), .HPROTS1(prot[1]), .HWRITES1(wr[1]), .HWDATAS1(wdata[1]),
        .HREADYS1(d_rdy[1]), .HREADYOUTS1(d_rdy[1]), .HRESPS1(d_resp[1]), .HRDATAS1(d_rdata[1]),
        .HSELS2(sel[2]), .HADDRS2(addr[2]), .HTRANSS2(trans[2]), .HSIZES2(size[2]),
        .HBURSTS2(burst[2]), .HPROTS2(prot[2]), .HWRITES2(wr[2]), .HWDATAS2(wdata[2]),
        .HREADYS2(d_rdy[2]), .HREADYOUTS2(d_rdy[2]), .HRESPS2(d_resp[2]), .HRDATAS2(d_rdata[2]),
        .HADDRM(d_haddr), .HTRANSM(d_htrans), .HSIZEM(d_hsize), .HBURSTM(d_hburst),
        .HPROTM(d_hprot), .HWRITEM(d_hwrite), .HWDATAM(d_hwdata), .HREADYM(d_hready),
        .HMASTERM(d_hmaster), .HREADYOUTM(readyout_m), .HRESPM(resp_m), .HRDATAM(rdata_m)
    );

    cm3_ahb_bus_arbiter #(.RR_MODE(1), .BURST_LOCK(1), .AW(32), .DW(32)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSELS0(sel[0]), .HADDRS0(addr[0]), .HTRANSS0(trans[0]), .HSIZES0(size[0]),
        .HBURSTS0(burst[0]), .HPROTS0(prot[0]), .HWRITES0(wr[0]), .HWDATAS0(wdata[0]),
        .HREADYS0(r_rdy[0]), .HREADYOUTS0(r_rdy[0]), .HRESPS0(r_resp[0]), .HRDATAS0(r_rdata[0]),
        .HSELS1(sel[1]), .HADDRS1(addr[1]), .HTRANSS1(trans[1]), .HSIZES1(size[1]),
        .HBURSTS1(burst[1]), .HPROTS1(prot[1]), .HWRITES1(wr[1]), .HWDATAS1(wdata[1]),
        .HREADYS1(r_rdy[1]), .HREADYOUTS1(r_rdy[1]), .HRESPS1(r_resp[1]), .HRDATAS1(r_rdata[1]),
        .HSELS2(sel[2]), .HADDRS2(addr[2]), .HTRANSS2(trans[2]), .HSIZES2(size[2]),
        .HBURSTS2(burst[2]), .HPROTS2(prot[2]), .HWRITES2(wr[2]), .HWDATAS2(wdata[2]),
        .HREADYS2(r_rdy[2]), .HREADYOUTS2(r_rdy[2]), .HRESPS2(r_resp[2]), .HRDATAS2(r_rdata[2]),
        .HADDRM(r_haddr), .HTRANSM(r_htrans), .HSIZEM(r_hsize), .HBURSTM(r_hburst),
        .HPROTM(r_hprot), .HWRITEM(r_hwrite), .HWDATAM(r_hwdata), .HREADYM(r_hready),
        .HMASTERM(r_hmaster), .HREADYOUTM(readyout_m), .HRESPM(resp_m), .HRDATAM(rdata_m)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  mst;
        logic [31:0] addr;
        logic        wr;
    } xfer_t;

    xfer_t exp_q [$];
    xfer_t exp_x;
    logic  sb_en  = 1'b0;
    logic  use_rr = 1'b0;

    logic [1:0]  mon_trans, mon_master;
    logic [31:0] mon_addr;
    logic        mon_write;
    assign mon_trans  = use_rr ? r_htrans  : d_htrans;
    assign mon_master = use_rr ? r_hmaster : d_hmaster;
    assign mon_addr   = use_rr ? r_haddr   : d_haddr;
    assign mon_write  = use_rr ? r_hwrite  : d_hwrite;

    // Every accepted NONSEQ/SEQ address phase must match the next queued expectation.
    always @(negedge HCLK) begin
        if (sb_en && HRESETn && readyout_m && mon_trans[1]) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_xfer", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_x = exp_q.pop_front();
                check_eq("sb_master", 64'(mon_master), 64'(exp_x.mst));
                check_eq("sb_addr", 64'(mon_addr), 64'(exp_x.addr));
                check_eq("sb_write", 64'(mon_write), 64'(exp_x.wr));
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    task automatic drv(input int p, input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [2:0] b);
        sel[p]   = (t != 2'b00);
        trans[p] = t;
        addr[p]  = a;
        wr[p]    = w;
        burst[p] = b;
        size[p]  = 3'b010;
        prot[p]  = 4'b0011;
    endtask

    task automatic idle(input int p);
        sel[p]   = 1'b0;
        trans[p] = 2'b00;
    endtask

    task automatic push(input logic [1:0] m, input logic [31:0] a, input logic w);
        exp_q.push_back('{mst: m, addr: a, wr: w});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            drv(i, 2'b00, 32'h0, 1'b0, 3'b000);
            wdata[i] = '0;
        end
        readyout_m = 1'b1;
        resp_m     = 2'b00;
        rdata_m    = '0;

        // Reset values
        repeat (2) cyc();
        mid();
        check_eq("rst_htransm", 64'(d_htrans), 64'd0);
        check_eq("rst_hmasterm", 64'(d_hmaster), 64'd0);
        check_eq("rst_hreadyouts", 64'(d_rdy), 64'b111);
        check_eq("rst_hresps0", 64'(d_resp[0]), 64'd0);
        check_eq("rst_rr_htransm", 64'(r_htrans), 64'd0);
        cyc();
        HRESETn = 1'b1;
        sb_en   = 1'b1;
        cyc();

        // Single port pass-through
        drv(2, NSEQ, 32'h0000_0100, 1'b0, 3'b000);
        push(2'd2, 32'h0000_0100, 1'b0);
        mid();
        check_eq("single_htransm", 64'(d_htrans), 64'(NSEQ));
        check_eq("single_hsizem", 64'(d_hsize), 64'b010);
        check_eq("single_hprotm", 64'(d_hprot), 64'b0011);
        check_eq("single_hreadym", 64'(d_hready), 64'(readyout_m));
        cyc();
        idle(2);
        rdata_m = 32'h1234_5678;
        mid();
        check_eq("single_hrdatas2", 64'(d_rdata[2]), 64'h1234_5678);
        check_eq("single_hreadyouts2", 64'(d_rdy[2]), 64'd1);
        cyc();

        // P0 and P2 collide, fixed priority
        drv(0, NSEQ, 32'h0000_0080, 1'b0, 3'b000);
        drv(2, NSEQ, 32'h0000_0200, 1'b0, 3'b000);
        push(2'd0, 32'h0000_0080, 1'b0);
        push(2'd2, 32'h0000_0200, 1'b0);
        mid();
        check_eq("prio_hmasterm_p0", 64'(d_hmaster), 64'd0);
        cyc();
        idle(0);
        idle(2);
        mid();
        check_eq("prio_hreadyouts2_wait", 64'(d_rdy[2]), 64'd0);
        check_eq("prio_held_addr", 64'(d_haddr), 64'h0000_0200);
        check_eq("prio_hmasterm_p2", 64'(d_hmaster), 64'd2);
        cyc();
        mid();
        check_eq("prio_hreadyouts2_data", 64'(d_rdy[2]), 64'd1);
        cyc();

        // P1 INCR4 with P0 arriving mid-burst
        drv(1, NSEQ, 32'h0000_0400, 1'b0, INCR4);
        push(2'd1, 32'h0000_0400, 1'b0);
        mid();
        check_eq("burst_hburstm", 64'(d_hburst), 64'(INCR4));
        cyc();
        drv(1, SEQ, 32'h0000_0404, 1'b0, INCR4);
        drv(0, NSEQ, 32'h0000_0090, 1'b0, 3'b000);
        push(2'd1, 32'h0000_0404, 1'b0);
        mid();
        check_eq("burst_beat2_owner", 64'(d_hmaster), 64'd1);
        cyc();
        drv(1, SEQ, 32'h0000_0408, 1'b0, INCR4);
        idle(0);
        push(2'd1, 32'h0000_0408, 1'b0);
        mid();
        check_eq("burst_p0_stalled", 64'(d_rdy[0]), 64'd0);
        check_eq("burst_beat3_owner", 64'(d_hmaster), 64'd1);
        cyc();
        drv(1, SEQ, 32'h0000_040C, 1'b0, INCR4);
        push(2'd1, 32'h0000_040C, 1'b0);
        push(2'd0, 32'h0000_0090, 1'b0);
        mid();
        check_eq("burst_beat4_owner", 64'(d_hmaster), 64'd1);
        cyc();
        idle(1);
        mid();
        check_eq("burst_p0_after", 64'(d_hmaster), 64'd0);
        check_eq("burst_p0_htransm", 64'(d_htrans), 64'(NSEQ));
        cyc();

        // Slave wait states during a P0 write, P2 waiting behind it
        drv(0, NSEQ, 32'h0000_0300, 1'b1, 3'b000);
        drv(2, NSEQ, 32'h0000_0500, 1'b0, 3'b000);
        push(2'd0, 32'h0000_0300, 1'b1);
        push(2'd2, 32'h0000_0500, 1'b0);
        cyc();
        idle(0);
        idle(2);
        wdata[0]   = 32'hDEAD_BEEF;
        wdata[2]   = 32'h1111_1111;
        readyout_m = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            check_eq("ws_hwdatam", 64'(d_hwdata), 64'hDEAD_BEEF);
            check_eq("ws_hreadyouts0", 64'(d_rdy[0]), 64'd0);
            check_eq("ws_p2_held_addr", 64'(d_haddr), 64'h0000_0500);
            check_eq("ws_p2_held_master", 64'(d_hmaster), 64'd2);
            cyc();
        end
        readyout_m = 1'b1;
        mid();
        check_eq("ws_hwdatam_last", 64'(d_hwdata), 64'hDEAD_BEEF);
        check_eq("ws_hreadyouts0_done", 64'(d_rdy[0]), 64'd1);
        cyc();
        wdata[0] = '0;
        wdata[2] = '0;

        // ERROR response on a P0 read
        drv(0, NSEQ, 32'h0000_0600, 1'b0, 3'b000);
        push(2'd0, 32'h0000_0600, 1'b0);
        cyc();
        idle(0);
        readyout_m = 1'b0;
        resp_m     = 2'b01;
        mid();
        check_eq("err1_hresps0", 64'(d_resp[0]), 64'd1);
        check_eq("err1_hresps1", 64'(d_resp[1]), 64'd0);
        check_eq("err1_hresps2", 64'(d_resp[2]), 64'd0);
        check_eq("err1_hreadyouts0", 64'(d_rdy[0]), 64'd0);
        cyc();
        readyout_m = 1'b1;
        mid();
        check_eq("err2_hresps0", 64'(d_resp[0]), 64'd1);
        check_eq("err2_hreadyouts0", 64'(d_rdy[0]), 64'd1);
        check_eq("err2_hresps2", 64'(d_resp[2]), 64'd0);
        cyc();
        resp_m = 2'b00;

        // Reset asserted while P1 waits
        drv(0, NSEQ, 32'h0000_0700, 1'b0, 3'b000);
        drv(1, NSEQ, 32'h0000_0704, 1'b0, 3'b000);
        push(2'd0, 32'h0000_0700, 1'b0);
        cyc();
        idle(0);
        readyout_m = 1'b0;
        mid();
        check_eq("rstw_p1_waiting", 64'(d_rdy[1]), 64'd0);
        #1;
        HRESETn = 1'b0;
        #1;
        check_eq("rstw_htransm", 64'(d_htrans), 64'd0);
        check_eq("rstw_hreadyouts1", 64'(d_rdy[1]), 64'd1);
        check_eq("rstw_hmasterm", 64'(d_hmaster), 64'd0);
        cyc();
        cyc();
        idle(1);
        readyout_m = 1'b1;
        HRESETn    = 1'b1;
        mid();
        check_eq("rstw_no_replay", 64'(d_htrans), 64'd0);
        cyc();

        // Round-robin with all three ports requesting continuously
        HRESETn = 1'b0;
        cyc();
        HRESETn = 1'b1;
        use_rr  = 1'b1;
        drv(0, NSEQ, 32'h0000_0A00, 1'b0, 3'b000);
        drv(1, NSEQ, 32'h0000_0B00, 1'b0, 3'b000);
        drv(2, NSEQ, 32'h0000_0C00, 1'b0, 3'b000);
        for (int k = 0; k < 6; k++) begin
            push(2'(k % 3), 32'h0000_0A00 + 32'(k % 3) * 32'h100, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            mid();
            check_eq("rr_hmasterm", 64'(r_hmaster), 64'(k % 3));
            cyc();
        end
        for (int i = 0; i < 3; i++) idle(i);
        sb_en = 1'b0;

        mid();
        check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
